food_gen: RTL and testbench
===========================

Name: food_gen

Overview:
- Upstream feeder of the snake controller. Drives the food coordinates consumed on its foodX/foodY inputs.
- Watches the snake head position and detects when the food is eaten. Then draws a new pseudo-random cell from an LFSR.
- Checks each candidate cell against the snake body through a probe handshake before publishing it. Optionally keeps a score.

Parameters:
- COLS, 16, grid width in cells. Must be a power of two, at most 16.
- ROWS, 8, grid height in cells. Must be a power of two, at most 16.
- LFSR_SEED, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'h0001.
- MAX_TRIES, 8, maximum candidates drawn per placement (1..15).
- INIT_X, 4'd12, food X after reset.
- INIT_Y, 4'd4, food Y after reset.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- headX  in  4  current snake head column
- headY  in  4  current snake head row
- headValid  in  1  one-cycle strobe: head has just moved, headX/headY valid
- probeReq  out  1  occupancy query request
- probeX  out  4  queried column, stable while probeReq=1
- probeY  out  4  queried row, stable while probeReq=1
- probeAck  in  1  query answered this cycle
- probeHit  in  1  queried cell is occupied by the body (sampled only when probeAck=1)
- foodX  out  4  food column
- foodY  out  4  food row
- foodValid  out  1  food coordinates are valid and displayable
- eaten  out  1  one-cycle pulse per food eaten
- score  out  8  eaten count, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT, lfsr=LFSR_SEED, tries=0.
  - foodX=INIT_X, foodY=INIT_Y, foodValid=0.
  - probeReq=0, probeX=0, probeY=0, eaten=0, score=0.
  - All outputs are registered.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk cycle regardless of state, so it is never 0.
  - Candidate X = lfsr[3:0] & (COLS-1). Candidate Y = lfsr[7:4] & (ROWS-1).
- INIT: next cycle foodValid<=1, go to WAIT.
- WAIT:
  - On headValid=1 with {headX,headY}=={foodX,foodY}: latch head into hX/hY, eaten<=1 for exactly one cycle, score<=score+1 (holds at 255), foodValid<=0, tries<=0, go to PICK.
  - headValid with no match: no action.
- PICK (1 cycle): candidate<=current LFSR cells, tries<=tries+1, go to PROBE.
- PROBE:
  - probeReq=1, probeX/probeY=candidate, held until probeAck=1.
  - On the probeAck cycle: reject if probeHit=1 or candidate=={hX,hY}.
  - Reject and tries<MAX_TRIES: probeReq<=0, go to PICK.
  - Otherwise (accepted, or tries==MAX_TRIES): go to PLACE.
  - After MAX_TRIES rejections the last candidate is used anyway, even if occupied.
- PLACE: foodX/foodY<=candidate, foodValid<=1, probeReq<=0, go to WAIT.
- Latency:
  - headValid sampled at edge N gives eaten=1 during cycle N+1.
  - Minimum eat-to-foodValid is 4 cycles, with probeAck returned in the first PROBE cycle.
- Boundary conditions:
  - headValid outside WAIT is ignored, including a head landing on the new candidate before PLACE.
  - probeAck while probeReq=0 is ignored.
  - probeReq is never dropped before probeAck, except by reset.
  - An asynchronous reset mid-PROBE drops probeReq immediately and loads INIT_X/INIT_Y.
  - Head bits above the grid range are compared as given; no masking.

Optional Feature:
- Macro FOOD_GEN_SCORE_EN.
- Defined: score counts as above, saturating at 8'd255.
- Undefined: score tied to 8'd0 and no counter is synthesised. eaten still pulses.

Test Plan:
- Release reset, hold headValid=0 for 5 cycles -> foodValid=1 from cycle 2, food=(12,4), probeReq=0, score=0.
- headValid pulse with head=(12,4) -> eaten=1 for one cycle, score=1, foodValid=0, probeReq rises 2 cycles later with probeX<16, probeY<8.
- Responder acks with probeHit=1 on the first 2 probes, then probeHit=0 -> 3 probes seen, food equals the third probe's cells, foodValid=1.
- Responder always returns probeHit=1, MAX_TRIES=8 -> exactly 8 probes, food = 8th candidate, foodValid=1.
- Responder delays probeAck by 10 cycles -> probeReq/probeX/probeY stable throughout; assert reset mid-wait -> probeReq=0 and food=(12,4) in the same cycle.
- 260 eat events with FOOD_GEN_SCORE_EN defined -> score stops at 255; rebuild without the macro -> score=0 throughout.

Source files
------------

// File: rtl/food_gen.sv
// Food placement for the snake game: detects the head eating the food, draws LFSR
// candidates, checks them against the body via a probe handshake. Score kept when FOOD_GEN_SCORE_EN is defined.
module food_gen #(
  parameter int          COLS      = 16,
  parameter int          ROWS      = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 8,
  parameter logic [3:0]  INIT_X    = 4'd12,
  parameter logic [3:0]  INIT_Y    = 4'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] headX,
  input  logic [3:0] headY,
  input  logic       headValid,
  output logic       probeReq,
  output logic [3:0] probeX,
  output logic [3:0] probeY,
  input  logic       probeAck,
  input  logic       probeHit,
  output logic [3:0] foodX,
  output logic [3:0] foodY,
  output logic       foodValid,
  output logic       eaten,
  output logic [7:0] score
);

  localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [3:0]  X_MASK  = 4'(COLS - 1);
  localparam logic [3:0]  Y_MASK  = 4'(ROWS - 1);
  localparam logic [3:0]  TRY_MAX = 4'(MAX_TRIES);

  typedef enum logic [2:0] {S_INIT, S_WAIT, S_PICK, S_PROBE, S_PLACE} state_t;

  // Galois step for x^16+x^14+x^13+x^11+1 (right-shifting form, tap mask 0xB400)
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_t      state;
  logic [15:0] lfsr;
  logic [3:0]  tries;
  logic [3:0]  hx;
  logic [3:0]  hy;
  logic        eat_hit;
  logic        reject;

  // Full 4-bit compare: head bits outside the grid are never masked away
  assign eat_hit = headValid && (headX == foodX) && (headY == foodY);
  // probeX/probeY double as the candidate register
  assign reject  = probeHit || ((probeX == hx) && (probeY == hy));

  // Free-running LFSR, advances every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Placement FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_INIT;
      tries     <= 4'd0;
      hx        <= 4'd0;
      hy        <= 4'd0;
      foodX     <= INIT_X;
      foodY     <= INIT_Y;
      foodValid <= 1'b0;
      probeReq  <= 1'b0;
      probeX    <= 4'd0;
      probeY    <= 4'd0;
      eaten     <= 1'b0;
    end else begin
      eaten <= 1'b0;
      case (state)
        S_INIT: begin
          foodValid <= 1'b1;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (eat_hit) begin
            hx        <= headX;
            hy        <= headY;
            eaten     <= 1'b1;
            foodValid <= 1'b0;
            tries     <= 4'd0;
            state     <= S_PICK;
          end
        end
        S_PICK: begin
          probeX   <= lfsr[3:0] & X_MASK;
          probeY   <= lfsr[7:4] & Y_MASK;
          probeReq <= 1'b1;
          tries    <= tries + 4'd1;
          state    <= S_PROBE;
        end
        S_PROBE: begin
          // The request is held until answered; the last candidate is kept once tries run out
          if (probeAck) begin
            probeReq <= 1'b0;
            if (reject && (tries < TRY_MAX)) begin
              state <= S_PICK;
            end else begin
              state <= S_PLACE;
            end
          end
        end
        S_PLACE: begin
          foodX     <= probeX;
          foodY     <= probeY;
          foodValid <= 1'b1;
          probeReq  <= 1'b0;
          state     <= S_WAIT;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

`ifdef FOOD_GEN_SCORE_EN
  logic [7:0] score_q;

  // Saturating eat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q <= 8'd0;
    end else if ((state == S_WAIT) && eat_hit && (score_q != 8'd255)) begin
      score_q <= score_q + 8'd1;
    end
  end

  assign score = score_q;
`else
  assign score = 8'd0;
`endif

endmodule

// File: tb/tb_food_gen.sv
// Self-checking bench for food_gen: per-cycle behavioural model compare plus directed checks.
module tb_food_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] headX = 4'd0;
  logic [3:0] headY = 4'd0;
  logic       headValid = 1'b0;
  logic       probeReq;
  logic [3:0] probeX;
  logic [3:0] probeY;
  logic       probeAck = 1'b0;
  logic       probeHit = 1'b0;
  logic [3:0] foodX;
  logic [3:0] foodY;
  logic       foodValid;
  logic       eaten;
  logic [7:0] score;

  always #5 clk = ~clk;

  food_gen dut (
    .clk(clk), .reset(reset), .headX(headX), .headY(headY), .headValid(headValid),
    .probeReq(probeReq), .probeX(probeX), .probeY(probeY), .probeAck(probeAck),
    .probeHit(probeHit), .foodX(foodX), .foodY(foodY), .foodValid(foodValid),
    .eaten(eaten), .score(score)
  );

`ifdef FOOD_GEN_SCORE_EN
  localparam int SC_EN = 1;
`else
  localparam int SC_EN = 0;
`endif

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_INIT = 0, P_WAIT = 1, P_PICK = 2, P_PROBE = 3, P_PLACE = 4;

  function automatic int lfsr_step(input int v);
    if (v % 2 == 1) return (v / 2) ^ 'hB400;
    return v / 2;
  endfunction

  int m_phase = P_INIT, m_lfsr = 'hACE1, m_tries = 0;
  int m_fx = 12, m_fy = 4, m_fv = 0, m_req = 0, m_px = 0, m_py = 0;
  int m_eaten = 0, m_score = 0, m_hx = 0, m_hy = 0;

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_phase = P_INIT; m_lfsr = 'hACE1; m_tries = 0;
      m_fx = 12; m_fy = 4; m_fv = 0; m_req = 0; m_px = 0; m_py = 0;
      m_eaten = 0; m_score = 0;
    end else begin
      m_eaten = 0;
      if (m_phase == P_INIT) begin
        m_fv = 1; m_phase = P_WAIT;
      end else if (m_phase == P_WAIT) begin
        if (headValid && headX == m_fx && headY == m_fy) begin
          m_hx = headX; m_hy = headY; m_eaten = 1; m_fv = 0; m_tries = 0;
          if (SC_EN == 1 && m_score < 255) m_score = m_score + 1;
          m_phase = P_PICK;
        end
      end else if (m_phase == P_PICK) begin
        m_px = (m_lfsr % 16) % 16;
        m_py = ((m_lfsr / 16) % 16) % 8;
        m_tries = m_tries + 1; m_req = 1; m_phase = P_PROBE;
      end else if (m_phase == P_PROBE) begin
        if (probeAck) begin
          m_req = 0;
          if ((probeHit || (m_px == m_hx && m_py == m_hy)) && m_tries < 8) m_phase = P_PICK;
          else m_phase = P_PLACE;
        end
      end else begin
        m_fx = m_px; m_fy = m_py; m_fv = 1; m_phase = P_WAIT;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("m_foodValid", foodValid, m_fv);
    chk("m_foodX", foodX, m_fx);
    chk("m_foodY", foodY, m_fy);
    chk("m_probeReq", probeReq, m_req);
    chk("m_eaten", eaten, m_eaten);
    chk("m_score", score, m_score);
    if (m_req == 1) begin
      chk("m_probeX", probeX, m_px);
      chk("m_probeY", probeY, m_py);
    end
  end

  // ---------------- probe responder ----------------
  int rsp_delay = 0, rsp_hits = 0, rsp_count = 0, rsp_wait = 0;
  bit rsp_stray = 1'b0;

  initial forever begin
    @(negedge clk);
    if (probeReq === 1'b1) begin
      if (rsp_wait >= rsp_delay) begin
        probeAck = 1'b1;
        probeHit = (rsp_count < rsp_hits);
        rsp_count++;
        rsp_wait = 0;
      end else begin
        probeAck = 1'b0;
        probeHit = 1'b0;
        rsp_wait++;
      end
    end else begin
      probeAck = rsp_stray;
      probeHit = rsp_stray;
      rsp_wait = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_food();
    int n = 0;
    while (foodValid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_food_timeout", foodValid, 16'd1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (probeReq !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_req_timeout", probeReq, 16'd1);
  endtask

  task automatic eat_pulse();
    headX = 4'(m_fx);
    headY = 4'(m_fy);
    headValid = 1'b1;
    @(negedge clk);
    headValid = 1'b0;
  endtask

  task automatic eat();
    eat_pulse();
    wait_food();
  endtask

  int hold_x, hold_y;

  initial begin
    // pin the model's LFSR against hand-stepped values
    chk("lfsr_pin1", 16'(lfsr_step('hACE1)), 16'hE270);
    chk("lfsr_pin2", 16'(lfsr_step('hE270)), 16'h7138);

    repeat (3) @(negedge clk);
    chk("rst_foodValid", foodValid, 16'd0);
    chk("rst_foodX", foodX, 16'd12);
    chk("rst_foodY", foodY, 16'd4);
    chk("rst_probeReq", probeReq, 16'd0);
    chk("rst_score", score, 16'd0);
    chk("rst_eaten", eaten, 16'd0);

    reset = 1'b1;
    rsp_hits = 2;
    repeat (5) @(negedge clk);
    chk("init_foodValid", foodValid, 16'd1);
    chk("init_foodX", foodX, 16'd12);
    chk("init_foodY", foodY, 16'd4);
    chk("init_probeReq", probeReq, 16'd0);

    // first eat: two hits then accept; first candidate from LFSR 0xB313 -> (3,1)
    headX = 4'd12; headY = 4'd4; headValid = 1'b1;
    @(negedge clk);
    headValid = 1'b0;
    chk("eat_pulse", eaten, 16'd1);
    chk("eat_score", score, 16'(SC_EN));
    chk("eat_foodValid", foodValid, 16'd0);
    @(negedge clk);
    chk("eat_pulse_once", eaten, 16'd0);
    chk("probe1_req", probeReq, 16'd1);
    chk("probe1_x", probeX, 16'd3);
    chk("probe1_y", probeY, 16'd1);
    wait_food();
    chk("probes_3", 16'(rsp_count), 16'd3);

    // every probe occupied: exactly MAX_TRIES probes, last candidate used
    rsp_count = 0; rsp_hits = 1000;
    eat();
    chk("probes_8", 16'(rsp_count), 16'd8);
    chk("allhit_foodValid", foodValid, 16'd1);

    // head row beyond grid must not alias onto the food row
    headX = 4'(m_fx); headY = 4'(m_fy + 8); headValid = 1'b1;
    @(negedge clk);
    headValid = 1'b0;
    chk("nomask_eaten", eaten, 16'd0);
    @(negedge clk);
    chk("nomask_foodValid", foodValid, 16'd1);

    // slow responder, head pulses on the candidate while probing, then reset mid-wait
    rsp_hits = 0; rsp_delay = 10;
    eat_pulse();
    wait_req();
    hold_x = m_px; hold_y = m_py;
    for (int i = 0; i < 5; i++) begin
      headX = 4'(hold_x); headY = 4'(hold_y); headValid = 1'b1;
      @(negedge clk);
      chk("hold_req", probeReq, 16'd1);
      chk("hold_x", probeX, 16'(hold_x));
      chk("hold_y", probeY, 16'(hold_y));
      chk("hold_no_eat", eaten, 16'd0);
    end
    headValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_probeReq", probeReq, 16'd0);
    chk("arst_foodX", foodX, 16'd12);
    chk("arst_foodY", foodY, 16'd4);
    chk("arst_foodValid", foodValid, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    rsp_delay = 0;
    wait_food();
    chk("rerun_foodX", foodX, 16'd12);
    chk("rerun_foodY", foodY, 16'd4);

    // score saturation with stray acks while idle
    rsp_stray = 1'b1;
    for (int i = 0; i < 260; i++) eat();
    rsp_stray = 1'b0;
    chk("score_final", score, 16'(SC_EN * 255));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
